// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared state encoding and frame field widths for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int c_BYTE_W     = 8;
    localparam int c_LEN_BYTES  = 2;
    localparam int c_WORD_BYTES = 4;
    localparam int c_CHK_BYTES  = 1;
    localparam int c_WORD_W     = c_BYTE_W * c_WORD_BYTES;
    localparam int c_LANE_W     = $clog2(c_WORD_BYTES);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream valid/ready channel feeding the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    import loader_pkg::*;

    logic                s_valid;
    logic [c_BYTE_W-1:0] s_data;
    logic                s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_word_packer
// Description : Collects four bytes little-endian into a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_word_packer
    import loader_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                i_accept,
    input  wire logic [c_BYTE_W-1:0] i_data,
    output logic      [c_WORD_W-1:0] o_word,
    output logic                     o_word_done
);

    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_WORD_BYTES - 1);

    logic [c_LANE_W-1:0]          r_byte_idx;
    logic [c_WORD_W-c_BYTE_W-1:0] r_lane;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx <= '0;
            r_lane     <= '0;
        end else if (i_accept) begin
            case (r_byte_idx)
                2'd0:    r_lane[7:0]   <= i_data;
                2'd1:    r_lane[15:8]  <= i_data;
                2'd2:    r_lane[23:16] <= i_data;
                default: ;
            endcase
            r_byte_idx <= r_byte_idx + c_LANE_W'(1);
        end
    end

    // The top byte is taken straight from the bus so the word is ready on its handshake edge.
    assign o_word      = {i_data, r_lane};
    assign o_word_done = i_accept && (r_byte_idx == c_LAST_LANE);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader writing a checksummed byte image into instruction
//               memory while holding the core in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_W = 8
)
(
    input  wire logic               clk,
    input  wire logic               reset,
    imem_loader_if.slave            s,
    output logic                    imem_we,
    output logic [63:0]             imem_addr,
    output logic [c_WORD_W-1:0]     imem_wdata,
    output logic                    core_hold,
    output logic                    done,
    output logic                    err,
    output logic [DEPTH_W:0]        words_loaded
);

    localparam logic [31:0] c_MAX_WORDS = 32'd1 << DEPTH_W;

    state_t                  r_state;
    logic                    r_ready;
    logic [15:0]             r_len;
    logic [c_BYTE_W-1:0]     r_sum;
    logic [DEPTH_W:0]        r_word_idx;
    logic                    r_imem_we;
    logic [63:0]             r_imem_addr;
    logic [c_WORD_W-1:0]     r_imem_wdata;
    logic                    r_core_hold;
    logic                    r_done;
    logic                    r_err;

    logic                    w_xfer;
    logic                    w_data_accept;
    logic [15:0]             w_len;
    logic [c_WORD_W-1:0]     w_word;
    logic                    w_word_done;
    logic [DEPTH_W:0]        w_next_idx;
    logic                    w_last_word;

    assign w_xfer        = s.s_valid && r_ready;
    assign w_data_accept = w_xfer && (r_state == DATA);
    assign w_len         = {s.s_data, r_len[7:0]};
    assign w_next_idx    = r_word_idx + (DEPTH_W+1)'(1);
    assign w_last_word   = (32'(w_next_idx) == 32'(r_len));

    byte_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_data_accept),
        .i_data      (s.s_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= LEN_LO;
            r_ready      <= 1'b0;
            r_len        <= '0;
            r_sum        <= '0;
            r_word_idx   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_hold  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            // Ready holds in every accepting state; terminal transitions clear it below.
            r_ready   <= (r_state != DONE) && (r_state != ERR);
            case (r_state)
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= s.s_data;
                        r_state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= s.s_data;
                        if (32'(w_len) > c_MAX_WORDS) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                            r_ready <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= CHK;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_sum <= r_sum + s.s_data;
                        if (w_word_done) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= 64'({r_word_idx, 2'b00});
                            r_imem_wdata <= w_word;
                            r_word_idx   <= w_next_idx;
                            if (w_last_word) begin
                                r_state <= CHK;
                            end
                        end
                    end
                end
                CHK: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (s.s_data == r_sum) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign s.s_ready    = r_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_hold    = r_core_hold;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_word_idx;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    import loader_pkg::*;

    localparam int DEPTH_W = 8;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_we;
    logic [63:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;
    logic [DEPTH_W:0]  words_loaded;

    int          vec = 0;
    int          miscompares = 0;
    int          cyc = 0;
    wr_t         sb[$];
    logic [31:0] img[$];

    imem_loader_if u_if ();

    imem_loader #(.DEPTH_W(DEPTH_W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .s            (u_if),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest pending word, in the cycle right after its last byte.
    always begin
        @(posedge clk);
        #2;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 64'(imem_we), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", 64'(imem_wdata), 64'(e.data));
                check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_s_ready", 64'(u_if.s_ready), 64'd0);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", imem_addr, 64'd0);
        check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        check("rst_core_hold", 64'(core_hold), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Entered and left on a falling edge; gap inserts idle cycles with s_valid low.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                             input logic [63:0] ea, input logic [31:0] ed);
        int t;
        repeat (gap) @(negedge clk);
        u_if.s_valid = 1'b1;
        u_if.s_data  = b;
        t = 0;
        while (u_if.s_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (u_if.s_ready !== 1'b1) begin
            check("s_ready_wait", 64'(u_if.s_ready), 64'd1);
        end else begin
            @(posedge clk);
            #1;
            if (push) sb.push_back('{ea, ed, cyc});
            @(negedge clk);
        end
        u_if.s_valid = 1'b0;
    endtask

    task automatic send_image(input int maxgap, input logic [7:0] chk_delta);
        logic [7:0]  sum;
        logic [15:0] n;
        logic [31:0] w;
        sum = 8'h00;
        n   = 16'(img.size());
        send_byte(n[7:0], $urandom_range(0, maxgap), 1'b0, 64'd0, 32'd0);
        send_byte(n[15:8], $urandom_range(0, maxgap), 1'b0, 64'd0, 32'd0);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                sum = sum + w[8*j +: 8];
                send_byte(w[8*j +: 8], $urandom_range(0, maxgap), (j == 3),
                          64'(i * 4), w);
            end
        end
        send_byte(sum + chk_delta, $urandom_range(0, maxgap), 1'b0, 64'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.s_valid = 1'b0;
        u_if.s_data  = 8'h00;

        // Single word, no gaps
        do_reset();
        img = '{32'h00500093};
        send_image(0, 8'h00);
        check("t1_done", 64'(done), 64'd1);
        check("t1_core_hold", 64'(core_hold), 64'd0);
        check("t1_err", 64'(err), 64'd0);
        check("t1_words", 64'(words_loaded), 64'd1);
        check("t1_s_ready", 64'(u_if.s_ready), 64'd0);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Three words with random idle gaps
        do_reset();
        img = '{32'h00500093, 32'h00100113, 32'hFFF00193};
        send_image(3, 8'h00);
        check("t2_done", 64'(done), 64'd1);
        check("t2_words", 64'(words_loaded), 64'd3);
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Bad checksum: word still written, loader errors out
        do_reset();
        img = '{32'h00500093};
        send_image(0, 8'h01);
        check("t3_err", 64'(err), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        check("t3_core_hold", 64'(core_hold), 64'd1);
        check("t3_s_ready", 64'(u_if.s_ready), 64'd0);
        check("t3_words", 64'(words_loaded), 64'd1);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Length one past capacity
        do_reset();
        send_byte(8'h01, 0, 1'b0, 64'd0, 32'd0);
        send_byte(8'h01, 0, 1'b0, 64'd0, 32'd0);
        check("t4_err", 64'(err), 64'd1);
        check("t4_s_ready", 64'(u_if.s_ready), 64'd0);
        u_if.s_valid = 1'b1;
        repeat (6) @(negedge clk);
        u_if.s_valid = 1'b0;
        check("t4_words", 64'(words_loaded), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_core_hold", 64'(core_hold), 64'd1);

        // Empty image
        do_reset();
        img.delete();
        send_image(0, 8'h00);
        check("t5_done", 64'(done), 64'd1);
        check("t5_words", 64'(words_loaded), 64'd0);
        check("t5_err", 64'(err), 64'd0);

        // Exactly full capacity
        do_reset();
        img.delete();
        for (int i = 0; i < 256; i++) begin
            img.push_back({8'hC3, 8'(i) ^ 8'h5A, ~8'(i), 8'(i)});
        end
        send_image(0, 8'h00);
        check("t6_done", 64'(done), 64'd1);
        check("t6_words", 64'(words_loaded), 64'd256);
        check("t6_err", 64'(err), 64'd0);
        check("t6_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-frame, then a clean reload from address 0
        do_reset();
        send_byte(8'h01, 0, 1'b0, 64'd0, 32'd0);
        send_byte(8'h00, 0, 1'b0, 64'd0, 32'd0);
        send_byte(8'h93, 0, 1'b0, 64'd0, 32'd0);
        send_byte(8'h00, 0, 1'b0, 64'd0, 32'd0);
        do_reset();
        img = '{32'h00500093};
        send_image(1, 8'h00);
        check("t7_done", 64'(done), 64'd1);
        check("t7_words", 64'(words_loaded), 64'd1);
        check("t7_sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
